r2_sum_ctrl: RTL

R2_SUM_CTRL -- requirements
Module: r2_sum_ctrl

---
 rtl/r2_sum_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/r2_sum_ctrl.sv
// Window-sum controller: aligns column-vector strobes to the datapath latency.
// Optional busy-cycle counter enabled with R2_SUM_CTRL_PERF_EN.
module r2_sum_ctrl #(
    parameter int COLS     = 7,
    parameter int ROWS     = 7,
    parameter int WIN      = 5,
    parameter int PIPE_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        ld_en,
    output logic        sum_en,
    output logic        cum_en,
    output logic        count_en,
    output logic        start_en,
    output logic        out_valid,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [9:0]  col_idx,
    output logic [9:0]  row_idx,
    output logic [15:0] perf_cycles
);

    localparam logic [9:0] LC  = 10'(COLS - 1);
    localparam logic [9:0] LR  = 10'(ROWS - WIN);
    localparam logic [9:0] LW  = 10'(WIN);
    localparam logic [9:0] LW1 = 10'(WIN - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [9:0]          r_col;
    logic [9:0]          r_row;
    logic [PIPE_LAT-1:0] r_sv;
    logic [9:0]          r_sc [PIPE_LAT];
    logic [9:0]          r_sr [PIPE_LAT];
    logic                r_ov;
    logic                r_err;

    logic       w_acc;
    logic       w_gap;
    logic       w_last;
    logic       w_start;
    logic       w_av;
    logic [9:0] w_ac;
    logic [9:0] w_ar;

    assign w_start = (r_state == IDLE) && start;
    assign w_acc   = (r_state == RUN) && in_valid;
    assign w_gap   = (r_state == RUN) && !in_valid && (r_col != 10'd0);
    assign w_last  = w_acc && (r_col == LC) && (r_row == LR);
    assign w_av    = r_sv[PIPE_LAT-1];
    assign w_ac    = r_sc[PIPE_LAT-1];
    assign w_ar    = r_sr[PIPE_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        done   = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = RUN;
            end
            RUN: begin
                if (w_gap) w_next = IDLE;
                else if (w_last) w_next = DRAIN;
            end
            DRAIN: begin
                if (r_sv == '0) w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_start || w_gap) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            if (r_col == LC) begin
                r_col <= '0;
                r_row <= r_row + 10'd1;
            end else begin
                r_col <= r_col + 10'd1;
            end
        end
    end

    // A broken row aborts the frame, so every in-flight strobe is discarded.
    always_ff @(posedge clk) begin
        if (rst || w_gap) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_sv[i] <= 1'b0;
                r_sc[i] <= '0;
                r_sr[i] <= '0;
            end
        end else begin
            r_sv[0] <= w_acc;
            r_sc[0] <= r_col;
            r_sr[0] <= r_row;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_sv[i] <= r_sv[i-1];
                r_sc[i] <= r_sc[i-1];
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_gap) begin
            r_ov <= 1'b0;
        end else begin
            r_ov <= w_av && (w_ac >= LW1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_err <= 1'b0;
        end else if (w_gap) begin
            r_err <= 1'b1;
        end
    end

    always_comb begin
        ld_en    = 1'b0;
        sum_en   = 1'b0;
        cum_en   = 1'b0;
        count_en = 1'b0;
        start_en = 1'b0;
        col_idx  = '0;
        row_idx  = '0;
        if (w_av) begin
            count_en = 1'b1;
            col_idx  = w_ac;
            row_idx  = w_ar;
            if (w_ac == 10'd0) begin
                ld_en    = 1'b1;
                start_en = 1'b1;
            end else begin
                sum_en = 1'b1;
            end
            if (w_ac >= LW) cum_en = 1'b1;
        end
    end

    assign out_valid = r_ov;
    assign err       = r_err;

`ifdef R2_SUM_CTRL_PERF_EN
    logic [15:0] r_perf;

    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_perf <= '0;
        end else if (busy && (r_perf != 16'hFFFF)) begin
            r_perf <= r_perf + 16'd1;
        end
    end

    assign perf_cycles = r_perf;
`else
    assign perf_cycles = '0;
`endif

endmodule
